// File: rtl/au_incdec_counter_pkg.sv
// ---------------------------------------------------------------------------
// au_incdec_pkg
// Shared definitions for the au_incdec_counter family:
//   - nxt_sel_e : next-state priority encoding (reset > load > step > hold)
//   - cnt_top   : largest count value for a WIDTH / MOD_VAL pair
//   - params_ok : legality check for the counter parameter set
// Optional feature macro used by the counter: AU_INCDEC_CNT_SAT_EN.
// ---------------------------------------------------------------------------
package au_incdec_pkg;

  typedef enum logic [1:0] {
    SEL_RST  = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_STEP = 2'd2,
    SEL_HOLD = 2'd3
  } nxt_sel_e;

  // MOD_VAL-1 when a modulus is given, otherwise 2^WIDTH-1.
  function automatic longint unsigned cnt_top(input int width, input int mod_val);
    longint unsigned one;
    one = 1;
    if (mod_val > 0)   return longint'(mod_val) - 1;
    else if (width >= 64) return '1;
    else               return (one << width) - one;
  endfunction

  function automatic bit params_ok(input int width, input int mod_val,
                                   input int arch, input int rst_val);
    longint lim;
    if (width < 1) return 1'b0;
    if (arch < 0 || arch > 2) return 1'b0;
    if (mod_val < 0) return 1'b0;
    if (mod_val != 0) begin
      if (mod_val < 2) return 1'b0;
      if (width < 62) begin
        lim = longint'(1) << width;
        if (longint'(mod_val) > lim) return 1'b0;
      end
    end
    if (rst_val < 0) return 1'b0;
    if (longint'(rst_val) > longint'(cnt_top(width, mod_val))) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/au_incdec_counter_if.sv
// ---------------------------------------------------------------------------
// au_incdec_counter_if
// Control/data bundle of the up/down counter.
//   master : drives en, ci, inc_dec, load, d, clr_ovf (and sat), reads q/co/tc/ovf
//   slave  : the counter side
// The sat signal exists only when AU_INCDEC_CNT_SAT_EN is defined.
// ---------------------------------------------------------------------------
interface au_incdec_counter_if #(parameter int WIDTH = 8) ();
  logic             en;
  logic             ci;
  logic             inc_dec;
  logic             load;
  logic [WIDTH-1:0] d;
`ifdef AU_INCDEC_CNT_SAT_EN
  logic             sat;
`endif
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             tc;
  logic             ovf;

`ifdef AU_INCDEC_CNT_SAT_EN
  modport master (output en, ci, inc_dec, load, d, sat, clr_ovf,
                  input  q, co, tc, ovf);
  modport slave  (input  en, ci, inc_dec, load, d, sat, clr_ovf,
                  output q, co, tc, ovf);
`else
  modport master (output en, ci, inc_dec, load, d, clr_ovf,
                  input  q, co, tc, ovf);
  modport slave  (input  en, ci, inc_dec, load, d, clr_ovf,
                  output q, co, tc, ovf);
`endif
endinterface

// File: rtl/au_incdec_counter_step.sv
// ---------------------------------------------------------------------------
// au_incdec_step
// Combinational +/-1 step with carry-in/carry-out.
//   a_i   : operand          ci_i : step request (0 passes a_i through)
//   dec_i : 0 inc, 1 dec     s_o  : result        co_o : carry/borrow out
// ARCH selects the carry structure: 0 ripple, 1 Kogge-Stone prefix,
// 2 behavioural add/subtract.
// ---------------------------------------------------------------------------
module au_incdec_step #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             ci_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o
);

  // A carry reaches bit i when ci and every lower bit propagates; a bit
  // propagates when it is 1 (increment) or 0 (decrement).
  logic [WIDTH-1:0] p;
  assign p = a_i ^ {WIDTH{dec_i}};

  if (ARCH == 2) begin : g_behav
    logic [WIDTH:0] ext;
    always_comb begin
      ext = '0;
      if (dec_i) ext = {1'b0, a_i} - {{WIDTH{1'b0}}, ci_i};
      else       ext = {1'b0, a_i} + {{WIDTH{1'b0}}, ci_i};
    end
    assign s_o  = ext[WIDTH-1:0];
    assign co_o = ext[WIDTH];
  end else if (ARCH == 1) begin : g_prefix
    logic [WIDTH:0] cur;
    logic [WIDTH:0] nxt;
    always_comb begin
      cur = {p, ci_i};
      nxt = '0;
      for (int l = 0; (1 << l) <= WIDTH; l++) begin
        nxt = cur;
        for (int k = 0; k <= WIDTH; k++) begin
          if (k >= (1 << l)) nxt[k] = cur[k] & cur[k - (1 << l)];
        end
        cur = nxt;
      end
    end
    assign s_o  = a_i ^ cur[WIDTH-1:0];
    assign co_o = cur[WIDTH];
  end else begin : g_ripple
    logic carry;
    always_comb begin
      carry = ci_i;
      s_o   = '0;
      for (int i = 0; i < WIDTH; i++) begin
        s_o[i] = a_i[i] ^ carry;
        carry  = carry & p[i];
      end
      co_o = carry;
    end
  end

endmodule

// File: rtl/au_incdec_counter.sv
// ---------------------------------------------------------------------------
// au_incdec_counter
// Registered up/down counter with programmable modulus, synchronous load,
// registered carry/borrow pulse, terminal-count flag and sticky overflow.
//   clk, rst : clock, synchronous active-high reset
//   bus      : au_incdec_counter_if.slave (en, ci, inc_dec, load, d,
//              clr_ovf, [sat] in; q, co, tc, ovf out)
// Optional saturation mode is compiled in with AU_INCDEC_CNT_SAT_EN.
// ---------------------------------------------------------------------------
module au_incdec_counter
  import au_incdec_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MOD_VAL = 0,
  parameter int ARCH    = 0,
  parameter int RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  au_incdec_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] TOP   = WIDTH'(cnt_top(WIDTH, MOD_VAL));
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  if (!params_ok(WIDTH, MOD_VAL, ARCH, RST_VAL)) begin : g_bad_params
    $fatal(1, "au_incdec_counter: illegal parameters WIDTH=%0d MOD_VAL=%0d ARCH=%0d RST_VAL=%0d",
           WIDTH, MOD_VAL, ARCH, RST_VAL);
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             step, step_co, wrap, sat_hit, clamp, ovf_set;
  logic             at_top, at_zero;
  logic [WIDTH-1:0] step_s, stepped;
  nxt_sel_e         sel;

  assign step    = bus.en & bus.ci;
  assign at_top  = (q_q == TOP);
  assign at_zero = (q_q == '0);

  au_incdec_step #(.WIDTH(WIDTH), .ARCH(ARCH)) u_step (
    .a_i  (q_q),
    .ci_i (step),
    .dec_i(bus.inc_dec),
    .s_o  (step_s),
    .co_o (step_co)
  );

  // Natural wrap is the step carry; a modulus needs its own TOP/zero detect.
  assign wrap    = (MOD_VAL == 0) ? step_co
                                  : (step & (bus.inc_dec ? at_zero : at_top));
  assign stepped = wrap ? (bus.inc_dec ? TOP : '0) : step_s;

`ifdef AU_INCDEC_CNT_SAT_EN
  assign sat_hit = wrap & bus.sat;
`else
  assign sat_hit = 1'b0;
`endif

  // Only a short modulus can leave load values above TOP.
  if (MOD_VAL > 0 && WIDTH < 62 && longint'(MOD_VAL) < (longint'(1) << WIDTH)) begin : g_clamp
    assign clamp = (bus.d > TOP);
  end else begin : g_noclamp
    assign clamp = 1'b0;
  end

  always_comb begin
    if (rst)           sel = SEL_RST;
    else if (bus.load) sel = SEL_LOAD;
    else if (step)     sel = SEL_STEP;
    else               sel = SEL_HOLD;
  end

  always_comb begin
    q_d     = q_q;
    co_d    = 1'b0;
    ovf_set = 1'b0;
    case (sel)
      SEL_RST:  q_d = RST_Q;
      SEL_LOAD: begin
        q_d     = clamp ? TOP : bus.d;
        ovf_set = clamp;
      end
      SEL_STEP: begin
        if (sat_hit) begin
          ovf_set = 1'b1;
        end else begin
          q_d     = stepped;
          co_d    = wrap;
          ovf_set = wrap;
        end
      end
      default: q_d = q_q;
    endcase
    // A new overflow event outranks a clear in the same cycle.
    ovf_d = (sel == SEL_RST) ? 1'b0 : (ovf_set | (ovf_q & ~bus.clr_ovf));
  end

  // Register stage: q, co, ovf
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RST_Q;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.co  = co_q;
  assign bus.ovf = ovf_q;
  assign bus.tc  = bus.inc_dec ? at_zero : at_top;

endmodule

// File: tb/tb_au_incdec_counter.sv
// ---------------------------------------------------------------------------
// tb_au_incdec_counter
// Directed bench over four counter configurations:
//   u_a WIDTH=4 natural wrap, u_b WIDTH=4 MOD_VAL=10 RST_VAL=3,
//   u_c WIDTH=3 (saturation when AU_INCDEC_CNT_SAT_EN), u_d WIDTH=1.
// ---------------------------------------------------------------------------
module tb_au_incdec_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  au_incdec_counter_if #(.WIDTH(4)) ia ();
  au_incdec_counter_if #(.WIDTH(4)) ib ();
  au_incdec_counter_if #(.WIDTH(3)) ic ();
  au_incdec_counter_if #(.WIDTH(1)) id ();

  au_incdec_counter #(.WIDTH(4), .MOD_VAL(0),  .ARCH(0), .RST_VAL(0)) u_a (.clk(clk), .rst(rst), .bus(ia));
  au_incdec_counter #(.WIDTH(4), .MOD_VAL(10), .ARCH(1), .RST_VAL(3)) u_b (.clk(clk), .rst(rst), .bus(ib));
  au_incdec_counter #(.WIDTH(3), .MOD_VAL(0),  .ARCH(2), .RST_VAL(0)) u_c (.clk(clk), .rst(rst), .bus(ic));
  au_incdec_counter #(.WIDTH(1), .MOD_VAL(0),  .ARCH(1), .RST_VAL(0)) u_d (.clk(clk), .rst(rst), .bus(id));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ia.en = 0; ia.ci = 0; ia.inc_dec = 0; ia.load = 0; ia.d = '0; ia.clr_ovf = 0;
    ib.en = 0; ib.ci = 0; ib.inc_dec = 0; ib.load = 0; ib.d = '0; ib.clr_ovf = 0;
    ic.en = 0; ic.ci = 0; ic.inc_dec = 0; ic.load = 0; ic.d = '0; ic.clr_ovf = 0;
    id.en = 0; id.ci = 0; id.inc_dec = 0; id.load = 0; id.d = '0; id.clr_ovf = 0;
`ifdef AU_INCDEC_CNT_SAT_EN
    ia.sat = 0; ib.sat = 0; ic.sat = 0; id.sat = 0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_a_q",   ia.q,   0);
    check("rst_a_co",  ia.co,  0);
    check("rst_a_ovf", ia.ovf, 0);
    check("rst_a_tc",  ia.tc,  0);
    check("rst_b_q",   ib.q,   3);
    check("rst_b_tc",  ib.tc,  0);
    check("rst_c_q",   ic.q,   0);
    check("rst_d_q",   id.q,   0);

    // natural wrap up, 16 steps
    ia.en = 1; ia.ci = 1; ia.inc_dec = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("wrap_a_q",  ia.q,  i % 16);
      check("wrap_a_co", ia.co, (i == 16) ? 1 : 0);
      if (i == 15) check("wrap_a_tc_top", ia.tc, 1);
    end
    check("wrap_a_ovf", ia.ovf, 1);
    ia.en = 0;
    tick();
    check("hold_a_q",   ia.q,   0);
    check("hold_a_co",  ia.co,  0);
    check("hold_a_ovf", ia.ovf, 1);
    ia.clr_ovf = 1;
    tick();
    ia.clr_ovf = 0;
    check("clr_a_ovf", ia.ovf, 0);

    // direction toggles every cycle from 0, increment first
    ia.en = 1; ia.ci = 1;
    for (int i = 0; i < 4; i++) begin
      ia.inc_dec = i[0];
      tick();
      check("tog_a_q",  ia.q,  (i % 2 == 0) ? 1 : 0);
      check("tog_a_co", ia.co, 0);
    end
    ia.en = 0; ia.inc_dec = 0;
    check("tog_a_ovf", ia.ovf, 0);

    // modulus 10, down through zero
    ib.load = 1; ib.d = 4'd0;
    tick();
    ib.load = 0;
    check("ld0_b_q",  ib.q,  0);
    check("ld0_b_co", ib.co, 0);
    ib.en = 1; ib.ci = 1; ib.inc_dec = 1;
    tick();
    check("dn_b_q",   ib.q,   9);
    check("dn_b_co",  ib.co,  1);
    check("dn_b_tc",  ib.tc,  0);
    check("dn_b_ovf", ib.ovf, 1);
    tick();
    check("dn2_b_q",  ib.q,  8);
    check("dn2_b_co", ib.co, 0);
    ib.en = 0; ib.clr_ovf = 1;
    tick();
    ib.clr_ovf = 0;
    check("clr_b_ovf", ib.ovf, 0);

    // clamped load, then clear colliding with a wrap
    ib.load = 1; ib.d = 4'd13;
    tick();
    ib.load = 0;
    check("clamp_b_q",   ib.q,   9);
    check("clamp_b_ovf", ib.ovf, 1);
    check("clamp_b_co",  ib.co,  0);
    ib.inc_dec = 0;
    #1;
    check("clamp_b_tc_up", ib.tc, 1);
    ib.en = 1; ib.ci = 1; ib.clr_ovf = 1;
    tick();
    check("wrapclr_b_q",   ib.q,   0);
    check("wrapclr_b_co",  ib.co,  1);
    check("wrapclr_b_ovf", ib.ovf, 1);
    ib.en = 0;
    tick();
    ib.clr_ovf = 0;
    check("clronly_b_ovf", ib.ovf, 0);
    check("clronly_b_co",  ib.co,  0);
    check("tc_b_up_at0",   ib.tc,  0);
    ib.inc_dec = 1;
    #1;
    check("tc_b_dn_at0", ib.tc, 1);
    ib.inc_dec = 0;

    // priority: reset over load and step, then load over step
    rst = 1; ib.load = 1; ib.d = 4'd5; ib.en = 1; ib.ci = 1;
    tick();
    rst = 0;
    check("prio_rst_b_q",  ib.q,  3);
    check("prio_rst_b_co", ib.co, 0);
    tick();
    check("prio_ld_b_q",  ib.q,  5);
    check("prio_ld_b_co", ib.co, 0);
    ib.load = 0;
    tick();
    check("step_b_q", ib.q, 6);
    ib.en = 0; ib.ci = 0;

    // WIDTH=3: boundary behaviour at 7 and 0
    ic.load = 1; ic.d = 3'd7;
    tick();
    ic.load = 0;
    check("ld7_c_q",  ic.q,  7);
    check("ld7_c_tc", ic.tc, 1);
    ic.en = 1; ic.ci = 1; ic.inc_dec = 0;
`ifdef AU_INCDEC_CNT_SAT_EN
    ic.sat = 1;
    tick();
    check("sat_c_q",   ic.q,   7);
    check("sat_c_co",  ic.co,  0);
    check("sat_c_ovf", ic.ovf, 1);
    ic.sat = 0;
    tick();
    check("nosat_c_q",  ic.q,  0);
    check("nosat_c_co", ic.co, 1);
    ic.sat = 1; ic.inc_dec = 1;
    tick();
    check("satdn_c_q",  ic.q,  0);
    check("satdn_c_co", ic.co, 0);
    ic.sat = 0;
`else
    tick();
    check("wrap_c_q",   ic.q,   0);
    check("wrap_c_co",  ic.co,  1);
    check("wrap_c_ovf", ic.ovf, 1);
`endif
    ic.inc_dec = 1;
    tick();
    check("borrow_c_q",  ic.q,  7);
    check("borrow_c_co", ic.co, 1);
    ic.en = 0; ic.ci = 0;

    // WIDTH=1 toggle, back-to-back carry/borrow
    id.en = 1; id.ci = 1; id.inc_dec = 0;
    tick();
    check("w1_up1_q",  id.q,  1);
    check("w1_up1_co", id.co, 0);
    tick();
    check("w1_up2_q",  id.q,  0);
    check("w1_up2_co", id.co, 1);
    id.inc_dec = 1;
    tick();
    check("w1_dn1_q",  id.q,  1);
    check("w1_dn1_co", id.co, 1);
    tick();
    check("w1_dn2_q",  id.q,  0);
    check("w1_dn2_co", id.co, 0);
    id.en = 0; id.ci = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
